// File: rtl/execute_stage_md.sv
// Integer ALU for the EX stage: add/sub, logic ops, set-less-than, shifts and pass-A.
// Latency: purely combinational.
// Backpressure: none; the result follows the operands.
module alu #(
    parameter int DATA_W = 32,
    parameter int AOP_W  = 5
) (
    input  logic [AOP_W-1:0]  op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] f,
    output logic              zero
);
    localparam int SH_W = $clog2(DATA_W);

    // Opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU,
    // 8 SLL, 9 SRL, 10 SRA (shift b by a), 11 PASSA (move source); others give 0.
    localparam logic [AOP_W-1:0] OP_ADD   = AOP_W'(0);
    localparam logic [AOP_W-1:0] OP_SUB   = AOP_W'(1);
    localparam logic [AOP_W-1:0] OP_AND   = AOP_W'(2);
    localparam logic [AOP_W-1:0] OP_OR    = AOP_W'(3);
    localparam logic [AOP_W-1:0] OP_XOR   = AOP_W'(4);
    localparam logic [AOP_W-1:0] OP_NOR   = AOP_W'(5);
    localparam logic [AOP_W-1:0] OP_SLT   = AOP_W'(6);
    localparam logic [AOP_W-1:0] OP_SLTU  = AOP_W'(7);
    localparam logic [AOP_W-1:0] OP_SLL   = AOP_W'(8);
    localparam logic [AOP_W-1:0] OP_SRL   = AOP_W'(9);
    localparam logic [AOP_W-1:0] OP_SRA   = AOP_W'(10);
    localparam logic [AOP_W-1:0] OP_PASSA = AOP_W'(11);

    logic [SH_W-1:0] shamt;
    assign shamt = a[SH_W-1:0];

    // Operation select
    always_comb begin
        f = '0;
        case (op)
            OP_ADD:   f = a + b;
            OP_SUB:   f = a - b;
            OP_AND:   f = a & b;
            OP_OR:    f = a | b;
            OP_XOR:   f = a ^ b;
            OP_NOR:   f = ~(a | b);
            OP_SLT:   f = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  f = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_SLL:   f = b << shamt;
            OP_SRL:   f = b >> shamt;
            OP_SRA:   f = DATA_W'($signed(b) >>> shamt);
            OP_PASSA: f = a;
            default:  f = '0;
        endcase
    end

    assign zero = (f == '0);
endmodule

// EX stage: ALU / conditional move, iterative mul/div with HI/LO, registered output slice.
// Latency: 1 edge for single-cycle ops; DATA_W+1 edges after the accepting edge for mul/div.
// Backpressure: in_ready drops while mul/div runs or the slice is held with out_ready low.
module execute_stage_md #(
    parameter int DATA_W = 32,
    parameter int AOP_W  = 5,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AOP_W-1:0]  alu_op,
    input  logic [3:0]        md_op,
    input  logic [1:0]        cond_wr,
    input  logic [1:0]        rs_sel,
    input  logic [1:0]        rt_sel,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] imm,
    input  logic              rf_we_in,
    input  logic [RA_W-1:0]   waddr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic              zero,
    output logic              rf_we_out,
    output logic [RA_W-1:0]   waddr_out
);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0]   op_a, op_b, alu_f;
    logic                alu_z;
    logic                is_long, is_signed, accept, cw_pass, fix_go, last_step;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   acc, wlo, md_b, hi, lo;
    logic                is_div, neg_q, neg_r, div0;
    logic [RA_W-1:0]     md_waddr;
    logic [DATA_W-1:0]   a_abs, b_abs;
    logic [DATA_W:0]     mul_sum, div_sh;
    logic                div_ge;
    logic [DATA_W-1:0]   div_diff;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   q_fix, r_fix, hi_res, lo_res;
    logic [DATA_W-1:0]   sc_data;
    logic                sc_we;

    assign op_a = (rs_sel == 2'b11) ? imm : rdata1;
    assign op_b = (rt_sel == 2'b11) ? imm : rdata2;

    alu #(.DATA_W(DATA_W), .AOP_W(AOP_W)) u_alu (
        .op   (alu_op),
        .a    (op_a),
        .b    (op_b),
        .f    (alu_f),
        .zero (alu_z)
    );

    // Codes 9..15 are not decoded and behave like NONE.
    assign is_long   = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                       (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign is_signed = (md_op == MD_MULT) || (md_op == MD_DIV);

    assign in_ready  = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready && !flush;
    // cond_wr 3 is reserved and falls through to unconditional.
    assign cw_pass   = (cond_wr == 2'd1) ? (rdata2 == '0) :
                       (cond_wr == 2'd2) ? (rdata2 != '0) : 1'b1;
    assign last_step = (cnt == CNT_W'(DATA_W - 1));
    assign fix_go    = (state == FIX) && (!out_valid || out_ready) && !flush;

    // Signed ops iterate on magnitudes; signs are reapplied in FIX.
    assign a_abs = (is_signed && op_a[DATA_W-1]) ? -op_a : op_a;
    assign b_abs = (is_signed && op_b[DATA_W-1]) ? -op_b : op_b;

    // Multiply: {acc,wlo} shifts right, adding the multiplicand when the low bit is set.
    assign mul_sum  = {1'b0, acc} + (wlo[0] ? {1'b0, md_b} : {(DATA_W+1){1'b0}});
    // Divide: restoring step; remainder in acc, dividend shifts out of wlo, quotient in.
    assign div_sh   = {acc, wlo[DATA_W-1]};
    assign div_ge   = (div_sh >= {1'b0, md_b});
    assign div_diff = div_sh[DATA_W-1:0] - md_b;

    assign prod_fix = neg_q ? -{acc, wlo} : {acc, wlo};
    assign q_fix    = neg_q ? -wlo : wlo;
    assign r_fix    = neg_r ? -acc : acc;
    // A zero divisor leaves the dividend in acc, so HI comes out right on its own.
    assign hi_res   = is_div ? r_fix : prod_fix[2*DATA_W-1:DATA_W];
    assign lo_res   = is_div ? (div0 ? {DATA_W{1'b1}} : q_fix) : prod_fix[DATA_W-1:0];

    // Result and write enable for ops that complete in the issue cycle
    always_comb begin
        sc_data = alu_f;
        sc_we   = rf_we_in && cw_pass;
        case (md_op)
            MD_MFHI: begin sc_data = hi; sc_we = rf_we_in; end
            MD_MFLO: begin sc_data = lo; sc_we = rf_we_in; end
            MD_MTHI,
            MD_MTLO: sc_we = 1'b0;
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state; flush always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && is_long) state_nxt = BUSY;
            BUSY:    if (last_step)         state_nxt = FIX;
            FIX:     if (fix_go)            state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Mul/div operand latch and one iteration per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            wlo      <= '0;
            md_b     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0     <= 1'b0;
            md_waddr <= '0;
        end else if (accept && is_long) begin
            cnt      <= '0;
            acc      <= '0;
            wlo      <= a_abs;
            md_b     <= b_abs;
            is_div   <= (md_op == MD_DIV) || (md_op == MD_DIVU);
            neg_q    <= is_signed && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            neg_r    <= is_signed && op_a[DATA_W-1];
            div0     <= (op_b == '0);
            md_waddr <= waddr_in;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                acc <= div_ge ? div_diff : div_sh[DATA_W-1:0];
                wlo <= {wlo[DATA_W-2:0], div_ge};
            end else begin
                acc <= mul_sum[DATA_W:1];
                wlo <= {mul_sum[0], wlo[DATA_W-1:1]};
            end
        end
    end

    // HI/LO: written by MTHI/MTLO at issue or by a completing mul/div
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (fix_go) begin
            hi <= hi_res;
            lo <= lo_res;
        end else if (accept && md_op == MD_MTHI) begin
            hi <= rdata1;
        end else if (accept && md_op == MD_MTLO) begin
            lo <= rdata1;
        end
    end

    // Output slice: load on single-cycle issue or FIX, hold until out_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_out   <= '0;
            zero      <= 1'b0;
            rf_we_out <= 1'b0;
            waddr_out <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && !is_long) begin
            out_valid <= 1'b1;
            alu_out   <= sc_data;
            zero      <= alu_z;
            rf_we_out <= sc_we;
            waddr_out <= waddr_in;
        end else if (fix_go) begin
            out_valid <= 1'b1;
            alu_out   <= lo_res;
            zero      <= 1'b0;
            rf_we_out <= 1'b0;
            waddr_out <= md_waddr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_execute_stage_md.sv
// Bench for execute_stage_md: random and directed issue against a behavioural model.
// Expected results queue at acceptance; a negedge monitor pops them on each handshake.
// Backpressure comes from a randomised or forced out_ready driver.
module tb_execute_stage_md;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [4:0]  alu_op;
    logic [3:0]  md_op;
    logic [1:0]  cond_wr, rs_sel, rt_sel;
    logic [31:0] rdata1, rdata2, imm;
    logic        rf_we_in;
    logic [4:0]  waddr_in;
    logic        out_valid, out_ready;
    logic [31:0] alu_out;
    logic        zero, rf_we_out;
    logic [4:0]  waddr_out;

    always #5 clk = ~clk;

    execute_stage_md #(.DATA_W(W), .AOP_W(5), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .md_op(md_op), .cond_wr(cond_wr),
        .rs_sel(rs_sel), .rt_sel(rt_sel),
        .rdata1(rdata1), .rdata2(rdata2), .imm(imm),
        .rf_we_in(rf_we_in), .waddr_in(waddr_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .zero(zero),
        .rf_we_out(rf_we_out), .waddr_out(waddr_out)
    );

    typedef struct {
        logic [31:0] d;
        logic        z;
        logic        we;
        logic [4:0]  wa;
    } exp_t;

    exp_t        q[$];
    logic [31:0] hi_m, lo_m;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rand_rdy = 1'b1;
    logic        forced_rdy = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_m(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return ~(a | b);
            5'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7:    return (a < b) ? 32'd1 : 32'd0;
            5'd8:    return b << a[4:0];
            5'd9:    return b >> a[4:0];
            5'd10:   return 32'($signed(b) >>> a[4:0]);
            5'd11:   return a;
            default: return 32'd0;
        endcase
    endfunction

    task automatic md_model(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] h, output logic [31:0] l);
        longint      p;
        logic [63:0] pu;
        int          sa, sb;
        sa = a;
        sb = b;
        h  = 32'd0;
        l  = 32'd0;
        case (mop)
            4'd1: begin p = longint'(sa) * longint'(sb); h = p[63:32]; l = p[31:0]; end
            4'd2: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
            4'd3: begin
                if (b == 32'd0) begin l = 32'hFFFFFFFF; h = a; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin l = a; h = 32'd0; end
                else begin l = sa / sb; h = sa % sb; end
            end
            4'd4: begin
                if (b == 32'd0) begin l = 32'hFFFFFFFF; h = a; end
                else begin l = a / b; h = a % b; end
            end
            default: ;
        endcase
    endtask

    // Model of one accepted issue: queue its expected result and update HI/LO.
    task automatic model_issue(input logic [4:0] aop, input logic [3:0] mop, input logic [1:0] cw,
                               input logic [1:0] rs, input logic [1:0] rt, input logic [31:0] r1,
                               input logic [31:0] r2, input logic [31:0] im, input logic we,
                               input logic [4:0] wa);
        logic [31:0] a, b, f, h, l;
        logic        pass;
        exp_t        e;
        a = (rs == 2'b11) ? im : r1;
        b = (rt == 2'b11) ? im : r2;
        f = alu_m(aop, a, b);
        e.wa = wa;
        e.z  = (f == 32'd0);
        e.d  = f;
        e.we = 1'b0;
        case (mop)
            4'd1, 4'd2, 4'd3, 4'd4: begin
                md_model(mop, a, b, h, l);
                hi_m = h;
                lo_m = l;
                e.d  = l;
                e.z  = 1'b0;
            end
            4'd5: begin e.d = hi_m; e.we = we; end
            4'd6: begin e.d = lo_m; e.we = we; end
            4'd7: hi_m = r1;
            4'd8: lo_m = r1;
            default: begin
                pass = (cw == 2'd1) ? (r2 == 32'd0) : (cw == 2'd2) ? (r2 != 32'd0) : 1'b1;
                e.we = we & pass;
            end
        endcase
        q.push_back(e);
    endtask

    // Present one request, wait (bounded) for acceptance; returns just after the accepting edge.
    task automatic issue(input logic [4:0] aop, input logic [3:0] mop, input logic [1:0] cw,
                         input logic [1:0] rs, input logic [1:0] rt, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] im, input logic we,
                         input logic [4:0] wa, input bit track);
        int waited;
        waited   = 0;
        alu_op   = aop;  md_op  = mop;  cond_wr = cw;
        rs_sel   = rs;   rt_sel = rt;
        rdata1   = r1;   rdata2 = r2;   imm     = im;
        rf_we_in = we;   waddr_in = wa;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL issue_timeout: in_ready low for %0d cycles, expected acceptance", waited);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        if (track) model_issue(aop, mop, cw, rs, rt, r1, r2, im, we, wa);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results still pending, expected 0", q.size());
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return $urandom_range(0, 20);
            default: return $urandom();
        endcase
    endfunction

    // out_ready driver: random, or forced for the hold test
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : forced_rdy;
        end
    end

    // Monitor: compare on each handshake, check the slice holds while stalled
    logic        held = 1'b0;
    logic [31:0] s_d;
    logic        s_z, s_we;
    logic [4:0]  s_wa;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (held) begin
                chk("hold_data", alu_out, s_d);
                chk("hold_ctrl", {zero, rf_we_out, waddr_out}, {s_z, s_we, s_wa});
            end
            if (out_ready) begin
                held = 1'b0;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %h, expected no result", alu_out);
                end else begin
                    e = q.pop_front();
                    chk("res_data", alu_out, e.d);
                    chk("res_zero", zero, e.z);
                    chk("res_we", rf_we_out, e.we);
                    chk("res_waddr", waddr_out, e.wa);
                end
            end else begin
                held = 1'b1;
                s_d = alu_out; s_z = zero; s_we = rf_we_out; s_wa = waddr_out;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, ir_bad;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        alu_op = '0; md_op = '0; cond_wr = '0; rs_sel = '0; rt_sel = '0;
        rdata1 = '0; rdata2 = '0; imm = '0; rf_we_in = 1'b0; waddr_in = '0;
        hi_m = 32'd0; lo_m = 32'd0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_out", alu_out, 0);
        chk("rst_ctrl", {zero, rf_we_out, waddr_out}, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD 5+7
        issue(5'd0, 4'd0, 2'd0, 2'd0, 2'd0, 32'd5, 32'd7, 32'd0, 1'b1, 5'd3, 1);
        chk("add_valid", out_valid, 1);
        chk("add_data", alu_out, 32'd12);
        chk("add_zero", zero, 0);
        chk("add_we", rf_we_out, 1);

        // Conditional moves
        issue(5'd11, 4'd0, 2'd1, 2'd0, 2'd0, 32'h55, 32'd0, 32'd0, 1'b1, 5'd4, 1);
        chk("movz_taken_we", rf_we_out, 1);
        issue(5'd11, 4'd0, 2'd1, 2'd0, 2'd0, 32'h55, 32'd3, 32'd0, 1'b1, 5'd4, 1);
        chk("movz_skip_we", rf_we_out, 0);
        issue(5'd11, 4'd0, 2'd2, 2'd0, 2'd0, 32'h55, 32'd3, 32'd0, 1'b1, 5'd4, 1);
        chk("movn_taken_we", rf_we_out, 1);

        // MULT -3*4 with latency measurement
        drain();
        issue(5'd0, 4'd1, 2'd0, 2'd0, 2'd0, 32'hFFFFFFFD, 32'd4, 32'd0, 1'b1, 5'd9, 1);
        cyc = 0;
        ir_bad = 0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid) break;
            if (in_ready) ir_bad++;
        end
        chk("mult_latency", cyc, W + 1);
        chk("mult_in_ready_low", ir_bad, 0);
        chk("mult_lo_out", alu_out, 32'hFFFFFFF4);
        chk("mult_we", rf_we_out, 0);
        issue(5'd0, 4'd6, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd1, 1);
        chk("mflo_mult", alu_out, 32'hFFFFFFF4);
        issue(5'd0, 4'd5, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd1, 1);
        chk("mfhi_mult", alu_out, 32'hFFFFFFFF);

        // DIV -7/2 and DIVU 7/0
        issue(5'd0, 4'd3, 2'd0, 2'd0, 2'd0, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 5'd0, 1);
        issue(5'd0, 4'd6, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd2, 1);
        chk("div_lo", alu_out, 32'hFFFFFFFD);
        issue(5'd0, 4'd5, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd2, 1);
        chk("div_hi", alu_out, 32'hFFFFFFFF);
        issue(5'd0, 4'd4, 2'd0, 2'd0, 2'd0, 32'd7, 32'd0, 32'd0, 1'b0, 5'd0, 1);
        issue(5'd0, 4'd6, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd2, 1);
        chk("divu0_lo", alu_out, 32'hFFFFFFFF);
        issue(5'd0, 4'd5, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd2, 1);
        chk("divu0_hi", alu_out, 32'h00000007);

        // Downstream stall for three cycles
        drain();
        rand_rdy = 1'b0;
        forced_rdy = 1'b0;
        @(posedge clk); #1;
        issue(5'd0, 4'd0, 2'd0, 2'd0, 2'd0, 32'd9, 32'd1, 32'd0, 1'b1, 5'd6, 1);
        md_op = 4'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stall_valid", out_valid, 1);
        chk("stall_data", alu_out, 32'd10);
        forced_rdy = 1'b1;
        rand_rdy = 1'b1;
        drain();

        // Flush: in-flight MULT dropped, HI/LO kept; issue under flush ignored
        issue(5'd0, 4'd7, 2'd0, 2'd0, 2'd0, 32'h1234, 32'd0, 32'd0, 1'b0, 5'd0, 1);
        issue(5'd0, 4'd8, 2'd0, 2'd0, 2'd0, 32'h5678, 32'd0, 32'd0, 1'b0, 5'd0, 1);
        issue(5'd0, 4'd1, 2'd0, 2'd0, 2'd0, 32'd7, 32'd9, 32'd0, 1'b0, 5'd0, 0);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        md_op = 4'd7; rdata1 = 32'hDEAD; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_issue_valid", out_valid, 0);
        issue(5'd0, 4'd5, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd7, 1);
        chk("flush_hi_kept", alu_out, 32'h1234);
        issue(5'd0, 4'd6, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd7, 1);
        chk("flush_lo_kept", alu_out, 32'h5678);

        // Reset during DIV iteration 10
        drain();
        issue(5'd0, 4'd3, 2'd0, 2'd0, 2'd0, 32'd100, 32'd3, 32'd0, 1'b0, 5'd0, 0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        issue(5'd0, 4'd5, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd8, 1);
        chk("postrst_hi", alu_out, 32'd0);
        issue(5'd0, 4'd6, 2'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd8, 1);
        chk("postrst_lo", alu_out, 32'd0);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            issue(5'($urandom_range(0, 12)), 4'($urandom_range(0, 8)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), pick(), pick(), pick(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        drain();
        chk("leftover_results", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
